// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and load/store, with byte-lane alignment.
// Optional macro ARB_FAIR_EN enables the fetch starvation override; without it data always wins.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic [3:0]    mem_write,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("MAX_WAIT must lie in 1..15");
  end

  logic       force_if;
  logic       grant_if;
  logic       grant_d;
  logic       d_acc_err;

  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_owner_q, rsp_owner_d;  // 0 = fetch, 1 = data
  logic [1:0] rsp_off_q,   rsp_off_d;
  logic       rsp_err_q,   rsp_err_d;
  logic       rsp_load_q,  rsp_load_d;

  logic       unused_if_addr_lsb;
  assign unused_if_addr_lsb = ^if_addr[1:0];

  always_comb begin
    case (d_size)
      2'd0:    d_acc_err = 1'b0;
      2'd1:    d_acc_err = d_addr[0];
      2'd2:    d_acc_err = (d_addr[1:0] != 2'b00);
      default: d_acc_err = 1'b1;
    endcase
  end

`ifdef ARB_FAIR_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // fair_q mirrors (wait_q == MAX_WAIT) so the override is a single flop in the grant path.
  logic [3:0] wait_q, wait_d;
  logic       fair_q, fair_d;

  always_comb begin
    wait_d = wait_q;
    if (!if_req || if_gnt)
      wait_d = 4'd0;
    else if (wait_q != MAX_WAIT_C)
      wait_d = wait_q + 4'd1;
    fair_d = (wait_d == MAX_WAIT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
      fair_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      fair_q <= fair_d;
    end
  end

  assign force_if = fair_q & if_req;
`else
  assign force_if = 1'b0;
`endif

  assign grant_if = rst_n & if_req & (force_if | ~d_req);
  assign grant_d  = rst_n & d_req & ~force_if;
  assign if_gnt   = grant_if;
  assign d_gnt    = grant_d;

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 4'b0000;
    mem_wdata = 32'h0;
    if (grant_if) begin
      mem_addr = {if_addr[AW-1:2], 2'b00};
      mem_read = 1'b1;
    end else if (grant_d) begin
      mem_addr = {d_addr[AW-1:2], 2'b00};
      // Error accesses still own the slot but must not touch the RAM.
      if (!d_acc_err) begin
        if (!d_we) begin
          mem_read = 1'b1;
        end else begin
          case (d_size)
            2'd0: begin
              mem_write = 4'b0001 << d_addr[1:0];
              mem_wdata = {4{d_wdata[7:0]}};
            end
            2'd1: begin
              mem_write = 4'b0011 << d_addr[1:0];
              mem_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
              mem_write = 4'b1111;
              mem_wdata = d_wdata;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = grant_if | grant_d;
    rsp_owner_d = grant_d;
    rsp_off_d   = grant_d ? d_addr[1:0] : 2'b00;
    rsp_err_d   = grant_d & d_acc_err;
    rsp_load_d  = grant_d & ~d_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_off_q   <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_off_q   <= rsp_off_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  always_comb begin
    if_rvalid = rsp_valid_q & ~rsp_owner_q;
    d_rvalid  = rsp_valid_q & rsp_owner_q;
    d_err     = d_rvalid & rsp_err_q;
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = (d_rvalid && rsp_load_q && !rsp_err_q) ? (mem_rdata >> {rsp_off_q, 3'b000}) : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, throughput and starvation sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:1023];

  mem_port_arbiter #(.MAX_WAIT(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read, byte-lane write.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= ram[mem_addr[11:2]];
    for (int b = 0; b < 4; b++)
      if (mem_write[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_size  = 2'd0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_size = size;
    d_addr = addr;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_if_gnt"},    32'(if_gnt),    32'h0);
    check({tag, "_d_gnt"},     32'(d_gnt),     32'h0);
    check({tag, "_mem_read"},  32'(mem_read),  32'h0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
    check({tag, "_d_rvalid"},  32'(d_rvalid),  32'h0);
    check({tag, "_d_err"},     32'(d_err),     32'h0);
    check({tag, "_d_rdata"},   d_rdata,        32'h0);
    check({tag, "_if_rdata"},  if_rdata,       32'h0);
  endtask

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] pre_addr;
    logic [31:0] pre_val;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic [31:0] e_addr;
    logic        e_read;
    logic [3:0]  e_write;
    logic [31:0] e_wdata;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_d_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    bit fair;
    logic exp_if;

    //          name            ifr  if_addr      dr   we   sz    d_addr       d_wdata       pre_addr     pre_val         eif  ed   e_addr       rd   wr     e_wdata       ifv  if_rdata      dv   d_rdata       err
    vecs[0]  = '{"fetch_0x10",   1'b1, 32'h10,  1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 32'h10,  1'b1, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{"fetch_0x13",   1'b1, 32'h13,  1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        32'h10,  32'h0BADF00D, 1'b1, 1'b0, 32'h10,  1'b1, 4'h0, 32'h0,        1'b1, 32'h0BADF00D, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{"st_byte_102",  1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 32'h102, 32'h000000AB, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h100, 1'b0, 4'h4, 32'hABABABAB, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[3]  = '{"ld_half_102",  1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 32'h102, 32'h0,        32'h100, 32'h12345678, 1'b0, 1'b1, 32'h100, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00001234, 1'b0};
    vecs[4]  = '{"ld_word_101",  1'b0, 32'h0,   1'b1, 1'b0, 2'd2, 32'h101, 32'h0,        32'hFFC, 32'h0,        1'b0, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[5]  = '{"ld_byte_103",  1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 32'h103, 32'h0,        32'h100, 32'hA1B2C3D4, 1'b0, 1'b1, 32'h100, 1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h000000A1, 1'b0};
    vecs[6]  = '{"st_word_200",  1'b0, 32'h0,   1'b1, 1'b1, 2'd2, 32'h200, 32'hCAFEF00D, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h200, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[7]  = '{"st_half_206",  1'b0, 32'h0,   1'b1, 1'b1, 2'd1, 32'h206, 32'h1234BEEF, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h204, 1'b0, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[8]  = '{"st_size3",     1'b0, 32'h0,   1'b1, 1'b1, 2'd3, 32'h0,   32'hFFFFFFFF, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h0,   1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[9]  = '{"ld_half_101",  1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 32'h101, 32'h0,        32'h100, 32'h99999999, 1'b0, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[10] = '{"both_req",     1'b1, 32'h20,  1'b1, 1'b0, 2'd2, 32'h30,  32'h0,        32'h30,  32'h11223344, 1'b0, 1'b1, 32'h30,  1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h11223344, 1'b0};
    vecs[11] = '{"idle",         1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        32'hFFC, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[12] = '{"ld_word_8",    1'b0, 32'h0,   1'b1, 1'b0, 2'd2, 32'h8,   32'h0,        32'h8,   32'h55AA55AA, 1'b0, 1'b1, 32'h8,   1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h55AA55AA, 1'b0};
    vecs[13] = '{"st_byte_3",    1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 32'h3,   32'h00000077, 32'hFFC, 32'h0,        1'b0, 1'b1, 32'h0,   1'b0, 4'h8, 32'h77777777, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[14] = '{"ld_half_0",    1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 32'h0,   32'h0,        32'h0,   32'hFEDCBA98, 1'b0, 1'b1, 32'h0,   1'b1, 4'h0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFEDCBA98, 1'b0};

`ifdef ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;

    // Reset with both requesters active: nothing may be granted.
    rst_n = 1'b0;
    idle_inputs();
    if_req = 1'b1;
    d_req  = 1'b1;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ram[vecs[i].pre_addr[11:2]] = vecs[i].pre_val;
      if_req  = vecs[i].if_req;
      if_addr = vecs[i].if_addr;
      d_req   = vecs[i].d_req;
      d_we    = vecs[i].d_we;
      d_size  = vecs[i].d_size;
      d_addr  = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata;
      #1;
      check({vecs[i].name, "_if_gnt"},    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      check({vecs[i].name, "_d_gnt"},     32'(d_gnt),     32'(vecs[i].e_d_gnt));
      check({vecs[i].name, "_mem_addr"},  mem_addr,       vecs[i].e_addr);
      check({vecs[i].name, "_mem_read"},  32'(mem_read),  32'(vecs[i].e_read));
      check({vecs[i].name, "_mem_write"}, 32'(mem_write), 32'(vecs[i].e_write));
      check({vecs[i].name, "_mem_wdata"}, mem_wdata,      vecs[i].e_wdata);
      @(posedge clk);
      #1;
      idle_inputs();
      check({vecs[i].name, "_if_rvalid"}, 32'(if_rvalid), 32'(vecs[i].e_if_rvalid));
      check({vecs[i].name, "_if_rdata"},  if_rdata,       vecs[i].e_if_rdata);
      check({vecs[i].name, "_d_rvalid"},  32'(d_rvalid),  32'(vecs[i].e_d_rvalid));
      check({vecs[i].name, "_d_rdata"},   d_rdata,        vecs[i].e_d_rdata);
      check({vecs[i].name, "_d_err"},     32'(d_err),     32'(vecs[i].e_d_err));
    end

    // Back-to-back fetches: a response and a new grant in the same cycle.
    @(negedge clk);
    ram[16] = 32'h11110000;
    ram[17] = 32'h22220000;
    if_req  = 1'b1;
    if_addr = 32'h40;
    @(posedge clk);
    #1;
    if_addr = 32'h44;
    #1;
    check("b2b_gnt2",    32'(if_gnt),    32'h1);
    check("b2b_rvalid1", 32'(if_rvalid), 32'h1);
    check("b2b_rdata1",  if_rdata,       32'h11110000);
    @(posedge clk);
    #1;
    idle_inputs();
    check("b2b_rvalid2", 32'(if_rvalid), 32'h1);
    check("b2b_rdata2",  if_rdata,       32'h22220000);
    @(posedge clk);
    #1;
    check("b2b_drain",   32'(if_rvalid), 32'h0);

    // Continuous contention: fetch only wins after MAX_WAIT denials when fairness is built in.
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h50;
    drive_load(32'h60, 2'd2);
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_if = fair && (c == 4 || c == 9);
      check($sformatf("starve_if_gnt_c%0d", c), 32'(if_gnt), 32'(exp_if));
      check($sformatf("starve_d_gnt_c%0d", c),  32'(d_gnt),  32'(!exp_if));
      @(negedge clk);
    end
    idle_inputs();
    @(posedge clk);
    @(negedge clk);

    // Reset lands before the edge that would register the load response.
    drive_load(32'h100, 2'd2);
    #1;
    check("rst_a_gnt_before", 32'(d_gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_a_gnt_during",  32'(d_gnt),    32'h0);
    check("rst_a_read_during", 32'(mem_read), 32'h0);
    @(posedge clk);
    #1;
    check_outputs_zero("rst_a_hold1");
    @(posedge clk);
    #1;
    check_outputs_zero("rst_a_hold2");
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("rst_a_after_rvalid", 32'(d_rvalid), 32'h0);

    // Reset while the load response is being delivered clears it immediately.
    @(negedge clk);
    ram[64] = 32'hA5A5A5A5;
    drive_load(32'h100, 2'd2);
    @(posedge clk);
    #1;
    idle_inputs();
    check("rst_b_rvalid_before", 32'(d_rvalid), 32'h1);
    check("rst_b_rdata_before",  d_rdata,       32'hA5A5A5A5);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_b_during");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_b_after_rvalid", 32'(d_rvalid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
